// File: rtl/epoch_sched_pkg.sv
// Shared state encoding and default dataset geometry for the epoch
// scheduler, LR lookup and training datapath.
package epoch_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } sched_state_e;

   localparam int EPOCH_MAX_DEF         = 24;
   localparam int SAMPLES_PER_EPOCH_DEF = 100;

   // Width needed to hold 0..n-1, never less than one bit.
   function automatic int min1_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/epoch_scheduler_wrap_counter.sv
// Modulo-MOD up counter with synchronous clear and a wrap flag that is
// high in the cycle an increment rolls the count from MOD-1 back to 0.
module wrap_counter
   import epoch_sched_pkg::*;
#(
   parameter int MOD = 4,
   parameter int W   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Exact compare against MOD-1: MOD need not be a power of two.
   assign wrap = inc && (cnt_q == LAST);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || wrap) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/epoch_scheduler.sv
// Training-loop sequencer: walks epochs x samples on a req/ack handshake.
// Optional abort input/aborted output when EPOCH_SCHED_ABORT_EN is defined.
module epoch_scheduler
   import epoch_sched_pkg::*;
#(
   parameter int EPOCH_MAX         = EPOCH_MAX_DEF,
   parameter int SAMPLES_PER_EPOCH = SAMPLES_PER_EPOCH_DEF,
   parameter int EW                = min1_clog2(EPOCH_MAX + 1),
   parameter int SW                = min1_clog2(SAMPLES_PER_EPOCH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          sample_ack,
`ifdef EPOCH_SCHED_ABORT_EN
   input  logic          abort,
   output logic          aborted,
`endif
   output logic          sample_req,
   output logic [SW-1:0] sample_idx,
   output logic [EW-1:0] epoch,
   output logic          epoch_first,
   output logic          busy,
   output logic          done
);

   localparam logic [EW-1:0] EPOCH_LAST  = EW'(EPOCH_MAX);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLES_PER_EPOCH - 1);

   sched_state_e  state_q, state_d;
   logic          req_q, req_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [EW-1:0] epoch_q, epoch_d;
   logic [SW-1:0] idx;
   logic          hs, fin, inc, clr, wrap, abort_hit;

`ifdef EPOCH_SCHED_ABORT_EN
   logic abt_q, abt_d;
   assign abort_hit = abort && (state_q == ST_RUN);
   assign aborted   = abt_q;
`else
   assign abort_hit = 1'b0;
`endif

   assign hs  = req_q && sample_ack;
   assign fin = hs && (epoch_q == EPOCH_LAST) && (idx == SAMPLE_LAST);
   // The final handshake leaves the indices at their last values.
   assign inc = hs && !fin && !abort_hit;
   assign clr = abort_hit || (state_q == ST_DONE);

   wrap_counter #(
      .MOD (SAMPLES_PER_EPOCH),
      .W   (SW)
   ) u_sample_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc),
      .clr  (clr),
      .cnt  (idx),
      .wrap (wrap)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      epoch_d = epoch_q;
`ifdef EPOCH_SCHED_ABORT_EN
      abt_d   = 1'b0;
`endif
      if (clr) begin
         epoch_d = '0;
      end else if (wrap) begin
         epoch_d = epoch_q + 1'b1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               req_d   = 1'b1;
               busy_d  = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort_hit) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               busy_d  = 1'b0;
`ifdef EPOCH_SCHED_ABORT_EN
               abt_d   = 1'b1;
`endif
            end else if (fin) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         epoch_q <= '0;
`ifdef EPOCH_SCHED_ABORT_EN
         abt_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         epoch_q <= epoch_d;
`ifdef EPOCH_SCHED_ABORT_EN
         abt_q   <= abt_d;
`endif
      end
   end

   assign sample_req  = req_q;
   assign sample_idx  = idx;
   assign epoch       = epoch_q;
   assign epoch_first = req_q && (idx == '0);
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
